// File: rtl/sha_256_pad.sv
// FIPS 180-4 message padder and 512-bit block sequencer for a SHA-224/256 core.
// Accepts 32-bit big-endian beats, pads with 0x80 / zero fill / 64-bit bit length.
module sha_256_pad (
   input  logic         clk,
   input  logic         rst,
   input  logic         in_valid,
   output logic         in_ready,
   input  logic [31:0]  in_data,
   input  logic [2:0]   in_bytes,
   input  logic         in_last,
   input  logic         in_op,
   output logic [511:0] Data,
   output logic [63:0]  Index,
   output logic         Operation,
   output logic         Enable,
   input  logic         Ready,
   output logic         Done
);

   typedef enum logic [1:0] {FILL, PAD, SEND, WAIT} state_t;

   state_t      state;
   logic [31:0] blk [16];
   logic [3:0]  wp;
   logic [63:0] len;
   logic        marker;
   logic        last_seen;
   logic        blk_final;
   logic [2:0]  k;
   logic [31:0] beat_word;
   logic        accept;

   always_comb begin
      k = (in_bytes > 3'd4) ? 3'd4 : in_bytes;
   end

   // Partial beats carry the 0x80 marker directly after the last valid byte.
   always_comb begin
      beat_word = in_data;
      case (k)
         3'd1:    beat_word = {in_data[31:24], 8'h80, 16'h0000};
         3'd2:    beat_word = {in_data[31:16], 8'h80, 8'h00};
         3'd3:    beat_word = {in_data[31:8], 8'h80};
         default: beat_word = in_data;
      endcase
   end

   always_comb begin
      accept = in_valid & in_ready;
   end

   always_comb begin
      Data = '0;
      for (int unsigned i = 0; i < 16; i++) begin
         Data[i*32 +: 32] = blk[i];
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= FILL;
         in_ready  <= 1'b0;
         wp        <= '0;
         len       <= '0;
         Index     <= '0;
         Operation <= 1'b0;
         marker    <= 1'b0;
         last_seen <= 1'b0;
         blk_final <= 1'b0;
         Enable    <= 1'b0;
         Done      <= 1'b0;
         for (int unsigned i = 0; i < 16; i++) begin
            blk[i] <= '0;
         end
      end else begin
         Enable <= 1'b0;
         Done   <= 1'b0;
         case (state)
            FILL: begin
               in_ready <= 1'b1;
               if (accept) begin
                  if (Index == '0 && wp == '0 && !last_seen) begin
                     Operation <= in_op;
                  end
                  len <= len + {58'd0, k, 3'b000};
                  if (k != 3'd0) begin
                     blk[wp] <= beat_word;
                     wp      <= wp + 4'd1;
                     if (k != 3'd4) begin
                        marker <= 1'b1;
                     end
                  end
                  if (in_last) begin
                     last_seen <= 1'b1;
                  end
                  // A full block wins over in_last; padding then continues after WAIT.
                  if (k != 3'd0 && wp == 4'd15) begin
                     state    <= SEND;
                     Enable   <= 1'b1;
                     in_ready <= 1'b0;
                  end else if (in_last) begin
                     state    <= PAD;
                     in_ready <= 1'b0;
                  end
               end
            end

            PAD: begin
               in_ready <= 1'b0;
               if (wp == 4'd15) begin
                  if (blk_final) begin
                     blk[15] <= len[31:0];
                  end else if (!marker) begin
                     blk[15] <= 32'h8000_0000;
                     marker  <= 1'b1;
                  end
                  state  <= SEND;
                  Enable <= 1'b1;
               end else if (wp == 4'd14 && marker) begin
                  blk[14]   <= len[63:32];
                  blk_final <= 1'b1;
                  wp        <= 4'd15;
               end else if (wp == 4'd14) begin
                  // No room for the length: word 15 stays zero and an extra block follows.
                  blk[14] <= 32'h8000_0000;
                  marker  <= 1'b1;
                  state   <= SEND;
                  Enable  <= 1'b1;
               end else begin
                  if (!marker) begin
                     blk[wp] <= 32'h8000_0000;
                     marker  <= 1'b1;
                  end
                  wp <= wp + 4'd1;
               end
            end

            SEND: begin
               in_ready <= 1'b0;
               state    <= WAIT;
            end

            WAIT: begin
               in_ready <= 1'b0;
               if (Ready) begin
                  Index     <= Index + 64'd1;
                  wp        <= '0;
                  blk_final <= 1'b0;
                  for (int unsigned i = 0; i < 16; i++) begin
                     blk[i] <= '0;
                  end
                  if (!last_seen) begin
                     state    <= FILL;
                     in_ready <= 1'b1;
                  end else if (blk_final) begin
                     Done      <= 1'b1;
                     Index     <= '0;
                     len       <= '0;
                     marker    <= 1'b0;
                     last_seen <= 1'b0;
                     state     <= FILL;
                     in_ready  <= 1'b1;
                  end else begin
                     state <= PAD;
                  end
               end
            end

            default: begin
               state    <= FILL;
               in_ready <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: doc/sha_256_pad.md
# sha_256_pad

Message padder and block sequencer that sits directly upstream of the SHA-224/256 compression core. It accepts a message as a stream of 32-bit big-endian words with valid/ready handshake, applies FIPS 180-4 padding (0x80 marker, zero fill, 64-bit bit-length), and presents 512-bit blocks to the core's `Data`/`Index`/`Operation`/`Enable` inputs. It waits for the core's `Ready` between blocks and flags message completion.

## Interface
- No parameters.
- `clk` in 1: clock, rising edge.
- `rst` in 1: synchronous, active-high reset.
- `in_valid` in 1: input beat valid.
- `in_ready` out 1: padder accepts a beat when `in_valid & in_ready`.
- `in_data` in 32: message word; `[31:24]` is the earliest byte.
- `in_bytes` in 3: valid bytes in the beat, left-aligned; 1..4, or 0 only with `in_last`; 5..7 treated as 4.
- `in_last` in 1: final beat of the message.
- `in_op` in 1: 0 = SHA-224, 1 = SHA-256; sampled on the first beat of a message.
- `Data` out 512: block to the core; message word i at `Data[i*32 +: 32]`.
- `Index` out 64: block number within the message, 0 for the first block.
- `Operation` out 1: latched `in_op`.
- `Enable` out 1: one-cycle start pulse to the core.
- `Ready` in 1: core completion pulse.
- `Done` out 1: one-cycle pulse when the final block of a message has been hashed.

## Operation
- Registers:
  - 16 x 32-bit block buffer.
  - 4-bit word pointer `wp`.
  - 64-bit bit-length counter `len`.
  - 64-bit `Index`.
  - `marker` flag: 0x80 has been placed.
  - `last_seen` flag.
  - `Operation`.
- States:
  - FILL: `in_ready` = 1.
    - Accept a beat with k = `in_bytes`. The first beat of a message (`Index`=0, `wp`=0, not `last_seen`) latches `in_op`.
    - k=4: store the word at `wp`, `wp`++.
    - k=1..3: keep the top k bytes, put 0x80 in byte k, zero the rest, store it, `wp`++, set `marker`.
    - k=0 (only legal with `in_last`): store nothing; `wp` unchanged. k=0 without `in_last`: beat consumed and ignored.
    - `len += 8*k`, modulo 2^64.
    - `in_last` sets `last_seen` and moves to PAD, unless `wp` wrapped to 0 (block full), which has priority and goes to SEND.
    - A full block (`wp` wraps 15→0) goes to SEND.
  - PAD: `in_ready` = 0; writes one word per cycle at `wp`, then `wp`++.
    - At `wp` = 0..13: write 0x80000000 if `marker`=0 (then set `marker`), else 0.
    - At `wp` = 14 with `marker`=1 on entry to the word: write `len[63:32]`, then `len[31:0]` at 15; block is final; go to SEND.
    - At `wp` = 14 with `marker`=0: write 0x80000000, set `marker`. Word 15 gets 0; block is not final; go to SEND.
    - At `wp` = 15 with `marker`=0: write 0x80000000 and set `marker`; block is not final; go to SEND.
    - Rule: the length goes in words 14/15 only if `marker` was set before word 14 of this block was written. Otherwise an extra block follows.
  - SEND: `Enable` = 1 for exactly one cycle; go to WAIT.
  - WAIT: hold `Data`, `Index`, `Operation` stable; wait for `Ready`=1.
    - Then `Index`++, `wp` = 0.
    - If not `last_seen`: go to FILL.
    - Else if the block just hashed was final: pulse `Done`, clear `Index`, `len`, `marker`, `last_seen`, and go to FILL.
    - Else: go to PAD.
- `Ready` outside WAIT is ignored.
- Buffer words not written for the current block read as 0; the buffer is cleared when `wp` returns to 0.

## Timing
- Reset values:
  - `in_ready`=0 during reset, 1 the cycle after, in FILL.
  - `Enable`=0, `Done`=0, `Index`=0, `Operation`=0, `Data`=0.
  - State FILL; all counters and flags cleared.
- Timing per step:
  - 16th word accepted at edge N: `Enable` high in cycle N+1.
  - PAD costs one cycle per remaining word; a `wp`=0 padding-only block takes 16 PAD cycles before SEND.
  - `Ready` sampled at edge M: next state is taken at M.
  - `Done` high in cycle M+1; `in_ready` is also high in M+1 for the next message.
- Core digest is valid when `Done` is seen; the core holds it until its next `Index`=0 block.
- Reset mid-message clears everything. A later stray `Ready` is ignored because the state is not WAIT.

## Test plan
- Empty message: one beat with k=0, `in_last`=1, op=1.
  - Required: one block, word0=0x80000000, words 1..15=0, `Index`=0, one `Enable` pulse.
  - After `Ready`: `Done`; digest e3b0c442...b855.
- "abc": beat 0x61626300, k=3, last, op=1.
  - Required: word0=0x61626380, word15=0x00000018, single block.
  - Digest ba7816bf...15ad. Repeat with op=0: digest 23097d22...
- 55-byte message: single block, 0x80 at byte 55, word15=0x000001B8.
- 56-byte message: block 0 has 0x80000000 at word14 and 0 at word15. Block 1 (`Index`=1) is all zero except word15=0x000001C0.
- 64-byte message: two blocks. Block 1 word0=0x80000000, word15=0x00000200.
- Backpressure and reset:
  - `in_valid` held high during SEND/WAIT: no beats accepted.
  - `rst` asserted in WAIT: `Enable`=0, `Index`=0; the following `Ready` pulse produces no `Done`.
